// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared constants for the RV32I memory stage.
//   - main-opcode field values (3-bit class prefixes and full 6-bit codes)
//   - funct3 access-size encodings (low two bits of funct3)
//   - helpers that tell whether a load/store funct3 is legal
package pipeline_pkg;

   // 3-bit class prefixes of the 6-bit main opcode
   localparam logic [2:0] OPC_LOAD   = 3'b010;
   localparam logic [2:0] OPC_STORE  = 3'b011;
   localparam logic [2:0] OPC_BRANCH = 3'b110;

   // Full 6-bit codes of the upper/jump group
   localparam logic [5:0] OPC_LUI    = 6'b111000;
   localparam logic [5:0] OPC_AUIPC  = 6'b111001;
   localparam logic [5:0] OPC_JAL    = 6'b111010;
   localparam logic [5:0] OPC_JALR   = 6'b111011;

   // LUI/AUIPC/JAL/JALR share this 4-bit prefix
   localparam logic [3:0] OPC_UJ_PREFIX = 4'b1110;

   // Access size carried in funct3[1:0]; funct3[2] selects zero extension
   localparam logic [1:0] F3_BYTE = 2'b00;
   localparam logic [1:0] F3_HALF = 2'b01;
   localparam logic [1:0] F3_WORD = 2'b10;

   function automatic logic load_f3_ok(input logic [2:0] f3);
      return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
             (f3 == 3'b100) || (f3 == 3'b101);
   endfunction

   function automatic logic store_f3_ok(input logic [2:0] f3);
      return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
   endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous data RAM, one 8-bit array per byte lane.
//   clk_i    clock
//   we_i     write strobe (qualified per lane by be_i)
//   be_i     byte enables, bit n covers wdata_i[8n+7:8n]
//   addr_i   word index
//   wdata_i  write data
//   rdata_o  registered read data (word at addr_i sampled at the edge)
module dmem_ram #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [3:0]    be_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem_lane [DEPTH_WORDS];
         logic [7:0] rd_lane_q;

         // Read-before-write: the read port returns the stored byte, and a
         // write in the same cycle becomes visible on the next read.
         always_ff @(posedge clk_i) begin
            if (we_i && be_i[gi]) begin
               mem_lane[addr_i] <= wdata_i[8*gi +: 8];
            end
            rd_lane_q <= mem_lane[addr_i];
         end

         assign rdata_o[8*gi +: 8] = rd_lane_q;
      end
   endgenerate

endmodule

// File: rtl/pipeline_mem.sv
// pipeline_mem: memory stage of the RV32I five-stage pipeline.
//   clk_i                 clock
//   reset_i               asynchronous active-low reset
//   alu_out_i             execute result / byte address
//   wdata_i               store data
//   rd_i                  destination register
//   main_opcode_i         6-bit main opcode
//   main_stall_i          execute slot is a bubble
//   rd_wb_o               writeback destination
//   indata_wb_o           writeback data
//   we_wb_o               register-file write enable
//   reg_forwarding_mem_o  forwarding value (same as indata_wb_o)
//   misalign_o            one-cycle pulse after a misaligned access
//   misalign_cnt_o        saturating misaligned-access count
module pipeline_mem
   import pipeline_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [31:0] alu_out_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  rd_i,
   input  logic [5:0]  main_opcode_i,
   input  logic        main_stall_i,
   output logic [4:0]  rd_wb_o,
   output logic [31:0] indata_wb_o,
   output logic        we_wb_o,
   output logic [31:0] reg_forwarding_mem_o,
   output logic        misalign_o,
   output logic [15:0] misalign_cnt_o
);

   // ---------------- decode (execute-side, combinational) ----------------
   logic [2:0]  f3;
   logic        is_load, is_store, ls_illegal, valid, mis_addr, mis_valid;
   logic        writes_rd, ram_we, we_d;
   logic [3:0]  be;
   logic [31:0] lane_data;

   assign f3 = main_opcode_i[2:0];

   always_comb begin
      is_load    = (main_opcode_i[5:3] == OPC_LOAD)  && load_f3_ok(f3);
      is_store   = (main_opcode_i[5:3] == OPC_STORE) && store_f3_ok(f3);
      // An undefined load/store size is squashed exactly like a bubble
      ls_illegal = ((main_opcode_i[5:3] == OPC_LOAD)  && !load_f3_ok(f3)) ||
                   ((main_opcode_i[5:3] == OPC_STORE) && !store_f3_ok(f3));
      valid      = !main_stall_i && !ls_illegal;

      mis_addr   = ((f3[1:0] == F3_HALF) && alu_out_i[0]) ||
                   ((f3[1:0] == F3_WORD) && (alu_out_i[1:0] != 2'b00));
      mis_valid  = valid && (is_load || is_store) && mis_addr;

      writes_rd  = (main_opcode_i[5:4] == 2'b00) || (main_opcode_i[5:4] == 2'b10) ||
                   is_load || (main_opcode_i[5:2] == OPC_UJ_PREFIX);
      we_d       = valid && writes_rd && (rd_i != 5'd0) && !(is_load && mis_addr);

      // reset_i gating drops a store whose edge coincides with reset assertion
      ram_we     = valid && is_store && !mis_addr && reset_i;

      be        = 4'b1111;
      lane_data = wdata_i;
      case (f3[1:0])
         F3_BYTE: begin
            be        = 4'b0001 << alu_out_i[1:0];
            lane_data = {4{wdata_i[7:0]}};
         end
         F3_HALF: begin
            be        = alu_out_i[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{wdata_i[15:0]}};
         end
         default: ;
      endcase
   end

   // ---------------- data RAM ----------------
   logic [31:0] rdata;

   dmem_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_dmem_ram (
      .clk_i   (clk_i),
      .we_i    (ram_we),
      .be_i    (be),
      .addr_i  (alu_out_i[AW+1:2]),
      .wdata_i (lane_data),
      .rdata_o (rdata)
   );

   // ---------------- stage register ----------------
   logic [4:0]  rd_q;
   logic [31:0] alu_q;
   logic        we_q, mis_q, load_q, load_mis_q;
   logic [2:0]  f3_q;
   logic [1:0]  lo_q;
   logic [15:0] cnt_q, cnt_d;

   assign cnt_d = (mis_valid && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         rd_q       <= '0;
         alu_q      <= '0;
         we_q       <= 1'b0;
         mis_q      <= 1'b0;
         load_q     <= 1'b0;
         load_mis_q <= 1'b0;
         f3_q       <= '0;
         lo_q       <= '0;
         cnt_q      <= '0;
      end else begin
         rd_q       <= rd_i;
         alu_q      <= alu_out_i;
         we_q       <= we_d;
         mis_q      <= mis_valid;
         load_q     <= is_load;
         load_mis_q <= is_load && mis_addr;
         f3_q       <= f3;
         lo_q       <= alu_out_i[1:0];
         cnt_q      <= cnt_d;
      end
   end

   // ---------------- load extraction (writeback side) ----------------
   logic [31:0] shifted, load_val, indata;

   always_comb begin
      shifted  = rdata >> {lo_q, 3'b000};
      load_val = shifted;
      case (f3_q[1:0])
         F3_BYTE: load_val = f3_q[2] ? {24'd0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
         F3_HALF: load_val = f3_q[2] ? {16'd0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
         default: ;
      endcase
      if (load_q) begin
         indata = load_mis_q ? 32'd0 : load_val;
      end else begin
         indata = alu_q;
      end
   end

   assign rd_wb_o              = rd_q;
   assign indata_wb_o          = indata;
   assign reg_forwarding_mem_o = indata;
   assign we_wb_o              = we_q;
   assign misalign_o           = mis_q;
   assign misalign_cnt_o       = cnt_q;

endmodule

// File: tb/tb_pipeline_mem.sv
// tb_pipeline_mem: directed self-checking bench for pipeline_mem.
module tb_pipeline_mem;

   localparam logic [5:0] R_ALU = 6'b000000;
   localparam logic [5:0] I_ALU = 6'b100000;
   localparam logic [5:0] LB    = 6'b010000;
   localparam logic [5:0] LH    = 6'b010001;
   localparam logic [5:0] LW    = 6'b010010;
   localparam logic [5:0] LBU   = 6'b010100;
   localparam logic [5:0] LHU   = 6'b010101;
   localparam logic [5:0] LILL  = 6'b010011;
   localparam logic [5:0] SB    = 6'b011000;
   localparam logic [5:0] SH    = 6'b011001;
   localparam logic [5:0] SW    = 6'b011010;
   localparam logic [5:0] BR    = 6'b110000;
   localparam logic [5:0] JAL   = 6'b111010;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] alu_out;
   logic [31:0] wdata;
   logic [4:0]  rd;
   logic [5:0]  opc;
   logic        stall;
   logic [4:0]  rd_wb;
   logic [31:0] indata_wb;
   logic        we_wb;
   logic [31:0] fwd;
   logic        mis;
   logic [15:0] mis_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipeline_mem #(.DEPTH_WORDS(1024)) dut (
      .clk_i                (clk),
      .reset_i              (reset_n),
      .alu_out_i            (alu_out),
      .wdata_i              (wdata),
      .rd_i                 (rd),
      .main_opcode_i        (opc),
      .main_stall_i         (stall),
      .rd_wb_o              (rd_wb),
      .indata_wb_o          (indata_wb),
      .we_wb_o              (we_wb),
      .reg_forwarding_mem_o (fwd),
      .misalign_o           (mis),
      .misalign_cnt_o       (mis_cnt)
   );

   // Present one op for one cycle; results are visible #1 after the edge.
   task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] r, input logic s);
      @(negedge clk);
      opc = o; alu_out = a; wdata = d; rd = r; stall = s;
      @(posedge clk);
      #1;
      $display("TX opc=%b addr=%h wdata=%h rd=%0d stall=%b -> rd_wb=%0d data=%h we=%b mis=%b cnt=%0d",
               o, a, d, r, s, rd_wb, indata_wb, we_wb, mis, mis_cnt);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; opc = R_ALU; alu_out = 32'h0; wdata = 32'h0; rd = 5'd0; stall = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (rd_wb !== 5'd0)      begin failures++; $display("FAIL reset_rd got=%0d exp=0", rd_wb); end
      checks++; if (indata_wb !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", indata_wb); end
      checks++; if (we_wb !== 1'b0)      begin failures++; $display("FAIL reset_we got=%b exp=0", we_wb); end
      checks++; if (fwd !== 32'd0)       begin failures++; $display("FAIL reset_fwd got=%h exp=0", fwd); end
      checks++; if (mis !== 1'b0)        begin failures++; $display("FAIL reset_mis got=%b exp=0", mis); end
      checks++; if (mis_cnt !== 16'd0)   begin failures++; $display("FAIL reset_cnt got=%0d exp=0", mis_cnt); end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_word();
      issue(SW, 32'h100, 32'hDEADBEEF, 5'd9, 1'b0);
      checks++; if (we_wb !== 1'b0) begin failures++; $display("FAIL sw_we got=%b exp=0", we_wb); end
      issue(LW, 32'h100, 32'h0, 5'd5, 1'b0);
      checks++; if (rd_wb !== 5'd5)            begin failures++; $display("FAIL lw_rd got=%0d exp=5", rd_wb); end
      checks++; if (indata_wb !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data got=%h exp=deadbeef", indata_wb); end
      checks++; if (we_wb !== 1'b1)            begin failures++; $display("FAIL lw_we got=%b exp=1", we_wb); end
      checks++; if (fwd !== 32'hDEADBEEF)       begin failures++; $display("FAIL lw_fwd got=%h exp=deadbeef", fwd); end
   endtask

   task automatic test_subword_load();
      issue(LB, 32'h103, 32'h0, 5'd1, 1'b0);
      checks++; if (indata_wb !== 32'hFFFFFFDE) begin failures++; $display("FAIL lb got=%h exp=ffffffde", indata_wb); end
      issue(LBU, 32'h103, 32'h0, 5'd1, 1'b0);
      checks++; if (indata_wb !== 32'h000000DE) begin failures++; $display("FAIL lbu got=%h exp=000000de", indata_wb); end
      issue(LH, 32'h102, 32'h0, 5'd1, 1'b0);
      checks++; if (indata_wb !== 32'hFFFFDEAD) begin failures++; $display("FAIL lh got=%h exp=ffffdead", indata_wb); end
      issue(LHU, 32'h102, 32'h0, 5'd1, 1'b0);
      checks++; if (indata_wb !== 32'h0000DEAD) begin failures++; $display("FAIL lhu got=%h exp=0000dead", indata_wb); end
      issue(LB, 32'h101, 32'h0, 5'd1, 1'b0);
      checks++; if (indata_wb !== 32'hFFFFFFBE) begin failures++; $display("FAIL lb_lane1 got=%h exp=ffffffbe", indata_wb); end
      issue(LHU, 32'h100, 32'h0, 5'd1, 1'b0);
      checks++; if (indata_wb !== 32'h0000BEEF) begin failures++; $display("FAIL lhu_lo got=%h exp=0000beef", indata_wb); end
   endtask

   task automatic test_subword_store();
      issue(SB, 32'h101, 32'h12345655, 5'd0, 1'b0);
      issue(LW, 32'h100, 32'h0, 5'd2, 1'b0);
      checks++; if (indata_wb !== 32'hDEAD55EF) begin failures++; $display("FAIL sb_result got=%h exp=dead55ef", indata_wb); end
      issue(SW, 32'h104, 32'h0, 5'd0, 1'b0);
      issue(SH, 32'h106, 32'h7777BEEF, 5'd0, 1'b0);
      issue(LW, 32'h104, 32'h0, 5'd2, 1'b0);
      checks++; if (indata_wb !== 32'hBEEF0000) begin failures++; $display("FAIL sh_result got=%h exp=beef0000", indata_wb); end
   endtask

   task automatic test_misalign();
      issue(SW, 32'h102, 32'h11111111, 5'd0, 1'b0);
      checks++; if (mis !== 1'b1)      begin failures++; $display("FAIL mis_sw_pulse got=%b exp=1", mis); end
      checks++; if (mis_cnt !== 16'd1) begin failures++; $display("FAIL mis_sw_cnt got=%0d exp=1", mis_cnt); end
      issue(LW, 32'h100, 32'h0, 5'd4, 1'b0);
      checks++; if (mis !== 1'b0)              begin failures++; $display("FAIL mis_pulse_len got=%b exp=0", mis); end
      checks++; if (indata_wb !== 32'hDEAD55EF) begin failures++; $display("FAIL mis_sw_nowrite got=%h exp=dead55ef", indata_wb); end
      issue(LH, 32'h101, 32'h0, 5'd3, 1'b0);
      checks++; if (we_wb !== 1'b0)      begin failures++; $display("FAIL mis_lh_we got=%b exp=0", we_wb); end
      checks++; if (indata_wb !== 32'd0) begin failures++; $display("FAIL mis_lh_data got=%h exp=0", indata_wb); end
      checks++; if (mis !== 1'b1)        begin failures++; $display("FAIL mis_lh_pulse got=%b exp=1", mis); end
      checks++; if (mis_cnt !== 16'd2)   begin failures++; $display("FAIL mis_lh_cnt got=%0d exp=2", mis_cnt); end
   endtask

   task automatic test_gating();
      issue(SW, 32'h100, 32'h0, 5'd0, 1'b1);
      issue(LW, 32'h100, 32'h0, 5'd6, 1'b0);
      checks++; if (indata_wb !== 32'hDEAD55EF) begin failures++; $display("FAIL stall_sw got=%h exp=dead55ef", indata_wb); end
      issue(LW, 32'h101, 32'h0, 5'd6, 1'b1);
      checks++; if (mis !== 1'b0)      begin failures++; $display("FAIL stall_mis got=%b exp=0", mis); end
      checks++; if (mis_cnt !== 16'd2) begin failures++; $display("FAIL stall_cnt got=%0d exp=2", mis_cnt); end
      checks++; if (we_wb !== 1'b0)    begin failures++; $display("FAIL stall_we got=%b exp=0", we_wb); end
      issue(R_ALU, 32'hCAFEF00D, 32'h0, 5'd0, 1'b0);
      checks++; if (we_wb !== 1'b0)            begin failures++; $display("FAIL rd0_we got=%b exp=0", we_wb); end
      checks++; if (indata_wb !== 32'hCAFEF00D) begin failures++; $display("FAIL rd0_data got=%h exp=cafef00d", indata_wb); end
      issue(R_ALU, 32'h12345678, 32'h0, 5'd7, 1'b0);
      checks++; if (we_wb !== 1'b1)            begin failures++; $display("FAIL ralu_we got=%b exp=1", we_wb); end
      checks++; if (indata_wb !== 32'h12345678) begin failures++; $display("FAIL ralu_data got=%h exp=12345678", indata_wb); end
      checks++; if (rd_wb !== 5'd7)            begin failures++; $display("FAIL ralu_rd got=%0d exp=7", rd_wb); end
      issue(I_ALU, 32'h00000042, 32'h0, 5'd8, 1'b0);
      checks++; if (we_wb !== 1'b1) begin failures++; $display("FAIL ialu_we got=%b exp=1", we_wb); end
      issue(JAL, 32'h00000404, 32'h0, 5'd1, 1'b0);
      checks++; if (we_wb !== 1'b1) begin failures++; $display("FAIL jal_we got=%b exp=1", we_wb); end
      issue(BR, 32'h00000001, 32'h0, 5'd1, 1'b0);
      checks++; if (we_wb !== 1'b0) begin failures++; $display("FAIL br_we got=%b exp=0", we_wb); end
      issue(LILL, 32'h101, 32'h0, 5'd4, 1'b0);
      checks++; if (we_wb !== 1'b0) begin failures++; $display("FAIL illegal_we got=%b exp=0", we_wb); end
      checks++; if (mis !== 1'b0)   begin failures++; $display("FAIL illegal_mis got=%b exp=0", mis); end
      issue(R_ALU, 32'h99, 32'h0, 5'd10, 1'b1);
      checks++; if (we_wb !== 1'b0)      begin failures++; $display("FAIL bubble_we got=%b exp=0", we_wb); end
      checks++; if (rd_wb !== 5'd10)     begin failures++; $display("FAIL bubble_rd got=%0d exp=10", rd_wb); end
      checks++; if (indata_wb !== 32'h99) begin failures++; $display("FAIL bubble_data got=%h exp=99", indata_wb); end
   endtask

   task automatic test_back_to_back();
      issue(SW, 32'h200, 32'hA5A51234, 5'd0, 1'b0);
      issue(LW, 32'h200, 32'h0, 5'd11, 1'b0);
      checks++; if (indata_wb !== 32'hA5A51234) begin failures++; $display("FAIL b2b_data got=%h exp=a5a51234", indata_wb); end
      issue(LW, 32'h1100, 32'h0, 5'd12, 1'b0);
      checks++; if (indata_wb !== 32'hDEAD55EF) begin failures++; $display("FAIL wrap_data got=%h exp=dead55ef", indata_wb); end
      issue(SW, 32'h300, 32'h00000001, 5'd0, 1'b0);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      opc = SW; alu_out = 32'h300; wdata = 32'h00000002; rd = 5'd0; stall = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      checks++; if (indata_wb !== 32'd0) begin failures++; $display("FAIL midrst_data got=%h exp=0", indata_wb); end
      checks++; if (mis_cnt !== 16'd0)   begin failures++; $display("FAIL midrst_cnt got=%0d exp=0", mis_cnt); end
      checks++; if (fwd !== 32'd0)       begin failures++; $display("FAIL midrst_fwd got=%h exp=0", fwd); end
      @(posedge clk);
      #1;
      stall = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      issue(LW, 32'h300, 32'h0, 5'd9, 1'b0);
      checks++; if (indata_wb !== 32'h00000001) begin failures++; $display("FAIL midrst_dropped got=%h exp=00000001", indata_wb); end
      checks++; if (we_wb !== 1'b1)             begin failures++; $display("FAIL midrst_we got=%b exp=1", we_wb); end
      issue(LW, 32'h200, 32'h0, 5'd9, 1'b0);
      checks++; if (indata_wb !== 32'hA5A51234) begin failures++; $display("FAIL midrst_keep got=%h exp=a5a51234", indata_wb); end
   endtask

   initial begin
      test_reset();
      test_word();
      test_subword_load();
      test_subword_store();
      test_misalign();
      test_gating();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
